// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Supervises an rPLL from its reference clock: pulses the PLL reset, waits for
//   LOCK, qualifies LOCK as stable, then releases the downstream reset. A lock
//   drop while running re-holds downstream reset and re-sequences. Repeated lock
//   timeouts end in a latched fault that only relock_req_i or rst_n can clear.
//
// Ports
//   clk           reference clock (never the PLL output)
//   rst_n         asynchronous active-low reset
//   pll_lock_i    raw PLL LOCK, asynchronous to clk
//   relock_req_i  one-cycle request to force a full re-sequence
//   pll_reset_o   rPLL RESET, active-high
//   sys_rst_n_o   downstream reset, active-low, high only while running
//   ready_o       high while running
//   fault_o       high while in the latched fault state
//   lock_lost_o   one-cycle pulse when lock drops while running
//   retry_cnt_o   lock timeouts since the last run entry or relock request

`timescale 1ns / 1ps

module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       relock_req_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic       lock_lost_o,
    output logic [3:0] retry_cnt_o
);

    localparam int unsigned MaxAb  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MaxCyc = (MaxAb > LOCK_TIMEOUT_CYCLES) ?
                                     MaxAb : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    localparam logic [CntW-1:0] RstLast    = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      RetryMax   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic [3:0]      retry_inc;
    logic            lock_meta_q, lock_s_q;
    logic            lock_lost_d;
    logic            pll_reset_q, sys_rst_n_q, ready_q, fault_q, lock_lost_q;

    // Saturating increment; the FSM leaves WAIT_LOCK for FAULT on reaching the
    // limit, so saturation is a safety net rather than a normal path.
    assign retry_inc = (retry_q == RetryMax) ? retry_q : retry_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        // Relock wins over lock loss and timeout; PLL_RST ignores it so the
        // reset pulse is never stretched.
        if (relock_req_i && (state_q != StPllRst)) begin
            state_d = StPllRst;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                StPllRst: begin
                    if (cnt_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (lock_s_q) begin
                        state_d = StStable;
                    end else if (cnt_q == TimeoutLast) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RetryMax) ? StFault : StPllRst;
                    end
                end
                StStable: begin
                    if (!lock_s_q) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        retry_d = 4'd0;
                    end
                end
                StRun: begin
                    if (!lock_s_q) begin
                        state_d     = StPllRst;
                        lock_lost_d = 1'b1;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StPllRst;
                end
            endcase
        end

        // Shared counter: clears on any state change, idles in RUN and FAULT.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == StRun) || (state_q == StFault)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Outputs are decoded from the next state and registered, so each output
    // reflects the current state glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == StPllRst);
            sys_rst_n_q <= (state_d == StRun);
            ready_q     <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign sys_rst_n_o = sys_rst_n_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign lock_lost_o = lock_lost_q;
    assign retry_cnt_o = retry_q;

endmodule
